// File: rtl/fp_mul_arbiter_if.sv
// Bundle between requesters, the shared product unit and fp_mul_arbiter.
// Ports (seen from the arbiter, modport slave):
//   i_req_valid/i_req_a/i_req_b : per-requester operand pair and valid
//   o_req_ready                 : one-hot combinational grant
//   o_mul_a/o_mul_b/o_mul_valid : registered job to the product unit
//   i_mul_prod                  : product, MUL_LAT cycles after o_mul_valid
//   o_rsp_valid/o_rsp_data      : one-hot response strobe and shared product
//   o_busy                      : combinational, any job in flight
interface fp_mul_arbiter_if #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned NB_INPUT = 13,
    parameter int unsigned NB_PROD  = 24
);
    logic [N_REQ-1:0]          i_req_valid;
    logic [N_REQ*NB_INPUT-1:0] i_req_a;
    logic [N_REQ*NB_INPUT-1:0] i_req_b;
    logic [N_REQ-1:0]          o_req_ready;
    logic [NB_INPUT-1:0]       o_mul_a;
    logic [NB_INPUT-1:0]       o_mul_b;
    logic                      o_mul_valid;
    logic [NB_PROD-1:0]        i_mul_prod;
    logic [N_REQ-1:0]          o_rsp_valid;
    logic [NB_PROD-1:0]        o_rsp_data;
    logic                      o_busy;

    // Environment side: requesters plus product unit.
    modport master (
        output i_req_valid, i_req_a, i_req_b, i_mul_prod,
        input  o_req_ready, o_mul_a, o_mul_b, o_mul_valid,
               o_rsp_valid, o_rsp_data, o_busy
    );

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_mul_prod,
        output o_req_ready, o_mul_a, o_mul_b, o_mul_valid,
               o_rsp_valid, o_rsp_data, o_busy
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one pipelined product unit between
// N_REQ requesters. One operand pair is accepted per cycle, issued through a
// register stage, tracked by a MUL_LAT-deep tag pipeline and returned to its
// requester with a one-hot response strobe.
// Ports:
//   clock   : rising-edge clock
//   i_reset : synchronous, active-high reset
//   bus     : fp_mul_arbiter_if.slave (request, product-unit, response)
module fp_mul_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned NB_INPUT = 13,
    parameter int unsigned NB_PROD  = 24,
    parameter int unsigned MUL_LAT  = 1
) (
    input  logic              clock,
    input  logic              i_reset,
    fp_mul_arbiter_if.slave   bus
);
    localparam int unsigned IDW = $clog2(N_REQ);
    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int unsigned CW  = IDW + 1;

    logic [IDW-1:0]      ptr_q, ptr_d;
    logic                mul_valid_q, mul_valid_d;
    logic [NB_INPUT-1:0] mul_a_q, mul_a_d;
    logic [NB_INPUT-1:0] mul_b_q, mul_b_d;
    logic [IDW-1:0]      issue_id_q, issue_id_d;
    logic [MUL_LAT-1:0]  tag_vld_q, tag_vld_d;
    logic [IDW-1:0]      tag_id_q [MUL_LAT];
    logic [IDW-1:0]      tag_id_d [MUL_LAT];
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NB_PROD-1:0]  rsp_data_q, rsp_data_d;

    logic [N_REQ-1:0]    grant_c;
    logic [IDW-1:0]      grant_id_c;
    logic                transfer_c;
    logic                found_c;
    logic [CW-1:0]       cand_c;

    // Rotating priority search starting at the pointer.
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        found_c    = 1'b0;
        cand_c     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_c = CW'(ptr_q) + CW'(i);
            if (cand_c >= CW'(N_REQ)) begin
                cand_c = cand_c - CW'(N_REQ);
            end
            if (!found_c && bus.i_req_valid[cand_c[IDW-1:0]]) begin
                grant_c[cand_c[IDW-1:0]] = 1'b1;
                grant_id_c               = cand_c[IDW-1:0];
                found_c                  = 1'b1;
            end
        end
    end

    // Grant bits are only ever set on valid requesters, so any grant is a transfer.
    assign transfer_c = |grant_c;

    // Pointer, issue stage, tag pipeline and response stage next-state.
    always_comb begin
        ptr_d       = ptr_q;
        mul_valid_d = transfer_c;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        issue_id_d  = issue_id_q;
        tag_vld_d   = '0;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            tag_id_d[i] = '0;
        end
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;

        if (transfer_c) begin
            ptr_d      = (grant_id_c == IDW'(N_REQ - 1)) ? '0 : grant_id_c + IDW'(1);
            mul_a_d    = bus.i_req_a[grant_id_c * NB_INPUT +: NB_INPUT];
            mul_b_d    = bus.i_req_b[grant_id_c * NB_INPUT +: NB_INPUT];
            issue_id_d = grant_id_c;
        end

        // Tags follow the issued job; the last entry lines up with i_mul_prod.
        tag_vld_d[0] = mul_valid_q;
        tag_id_d[0]  = issue_id_q;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        if (tag_vld_q[MUL_LAT-1]) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                rsp_valid_d[k] = (tag_id_q[MUL_LAT-1] == IDW'(k));
            end
            rsp_data_d = bus.i_mul_prod;
        end
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            ptr_q       <= '0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            issue_id_q  <= '0;
            tag_vld_q   <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            issue_id_q  <= issue_id_d;
            tag_vld_q   <= tag_vld_d;
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.o_req_ready = grant_c;
    assign bus.o_mul_a     = mul_a_q;
    assign bus.o_mul_b     = mul_b_q;
    assign bus.o_mul_valid = mul_valid_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_busy      = mul_valid_q | (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: one instance at MUL_LAT=1, one at MUL_LAT=3.
module tb_fp_mul_arbiter;
    logic clock;
    logic i_reset;

    int total = 0;
    int bad   = 0;

    logic [12:0] opa [4];
    logic [12:0] opb [4];

    fp_mul_arbiter_if #(.N_REQ(4), .NB_INPUT(13), .NB_PROD(24)) ifa ();
    fp_mul_arbiter_if #(.N_REQ(4), .NB_INPUT(13), .NB_PROD(24)) ifb ();

    fp_mul_arbiter #(.N_REQ(4), .NB_INPUT(13), .NB_PROD(24), .MUL_LAT(1)) dut_a (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (ifa)
    );

    fp_mul_arbiter #(.N_REQ(4), .NB_INPUT(13), .NB_PROD(24), .MUL_LAT(3)) dut_b (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (ifb)
    );

    // Product-unit model; the key makes a=0E00, b=0F80 yield 24'h00ABCD.
    function automatic logic [23:0] prod_fn(input logic [12:0] a, input logic [12:0] b);
        return {a[11:0], b[11:0]} ^ 24'hE0A44D;
    endfunction

    logic [23:0] pa;
    logic [23:0] pb [3];

    always @(posedge clock) begin
        pa    <= prod_fn(ifa.o_mul_a, ifa.o_mul_b);
        pb[0] <= prod_fn(ifb.o_mul_a, ifb.o_mul_b);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    assign ifa.i_mul_prod = pa;
    assign ifb.i_mul_prod = pb[2];

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_ops();
        for (int k = 0; k < 4; k++) begin
            ifa.i_req_a[k*13 +: 13] = opa[k];
            ifa.i_req_b[k*13 +: 13] = opb[k];
            ifb.i_req_a[k*13 +: 13] = opa[k];
            ifb.i_req_b[k*13 +: 13] = opb[k];
        end
    endtask

    task automatic fair_ops();
        for (int k = 0; k < 4; k++) begin
            opa[k] = 13'(13'h100 * k + 1);
            opb[k] = 13'(13'h040 * k + 3);
        end
        load_ops();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clock = 1'b0;
        i_reset = 1'b1;
        ifa.i_req_valid = 4'b1111;
        ifb.i_req_valid = 4'b0000;
        fair_ops();

        // Reset held three edges with all requesters valid.
        tick(); tick(); tick();
        i_reset = 1'b0;
        #1;
        chk("rst_mul_valid", 32'(ifa.o_mul_valid), 32'd0);
        chk("rst_rsp_valid", 32'(ifa.o_rsp_valid), 32'd0);
        chk("rst_busy",      32'(ifa.o_busy),      32'd0);
        chk("rst_ready",     32'(ifa.o_req_ready), 32'h1);
        chk("rst_b_busy",    32'(ifb.o_busy),      32'd0);

        // Fairness: all valid for 12 grants, responses 3 cycles later.
        for (int i = 0; i < 15; i++) begin
            ifa.i_req_valid = (i < 12) ? 4'b1111 : 4'b0000;
            #1;
            if (i < 12)
                chk($sformatf("fair_rdy%0d", i), 32'(ifa.o_req_ready), 32'(4'b0001 << (i % 4)));
            if (i >= 1)
                chk($sformatf("fair_busy%0d", i), 32'(ifa.o_busy), 32'd1);
            if (i >= 3) begin
                chk($sformatf("fair_rspv%0d", i), 32'(ifa.o_rsp_valid), 32'(4'b0001 << ((i - 3) % 4)));
                chk($sformatf("fair_rspd%0d", i), 32'(ifa.o_rsp_data),
                    32'(prod_fn(opa[(i - 3) % 4], opb[(i - 3) % 4])));
            end
            tick();
        end
        chk("fair_end_rspv", 32'(ifa.o_rsp_valid), 32'd0);
        chk("fair_end_busy", 32'(ifa.o_busy),      32'd0);

        // Single request from requester 2.
        opa[2] = 13'h0E00;
        opb[2] = 13'h0F80;
        load_ops();
        ifa.i_req_valid = 4'b0100;
        #1;
        chk("one_ready", 32'(ifa.o_req_ready), 32'h4);
        tick();
        ifa.i_req_valid = 4'b0000;
        #1;
        chk("one_mulv",  32'(ifa.o_mul_valid), 32'd1);
        chk("one_mula",  32'(ifa.o_mul_a),     32'h0E00);
        chk("one_mulb",  32'(ifa.o_mul_b),     32'h0F80);
        chk("one_rsp1",  32'(ifa.o_rsp_valid), 32'd0);
        tick();
        chk("one_rsp2",  32'(ifa.o_rsp_valid), 32'd0);
        chk("one_busy2", 32'(ifa.o_busy),      32'd1);
        tick();
        chk("one_rspv",  32'(ifa.o_rsp_valid), 32'h4);
        chk("one_rspd",  32'(ifa.o_rsp_data),  32'h00ABCD);
        tick();
        chk("one_rsp4",  32'(ifa.o_rsp_valid), 32'd0);
        chk("one_busy4", 32'(ifa.o_busy),      32'd0);

        // Skip and wrap: pointer is 3, requesters 0 and 2 valid.
        fair_ops();
        ifa.i_req_valid = 4'b0101;
        #1;
        chk("wrap_rdy0", 32'(ifa.o_req_ready), 32'h1);
        tick();
        chk("wrap_rdy1", 32'(ifa.o_req_ready), 32'h4);
        tick();
        ifa.i_req_valid = 4'b0000;
        #1;
        chk("wrap_mula", 32'(ifa.o_mul_a), 32'(opa[2]));
        tick();
        chk("wrap_rspv0", 32'(ifa.o_rsp_valid), 32'h1);
        chk("wrap_rspd0", 32'(ifa.o_rsp_data),  32'(prod_fn(opa[0], opb[0])));
        tick();
        chk("wrap_rspv2", 32'(ifa.o_rsp_valid), 32'h4);
        chk("wrap_rspd2", 32'(ifa.o_rsp_data),  32'(prod_fn(opa[2], opb[2])));
        tick();
        chk("wrap_busy", 32'(ifa.o_busy), 32'd0);

        // Reset mid-flight: grant 1 then 3, reset on the following edge.
        ifa.i_req_valid = 4'b0010;
        #1;
        chk("mid_rdy1", 32'(ifa.o_req_ready), 32'h2);
        tick();
        ifa.i_req_valid = 4'b1000;
        #1;
        chk("mid_rdy3", 32'(ifa.o_req_ready), 32'h8);
        tick();
        ifa.i_req_valid = 4'b0000;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        chk("mid_rspv_a", 32'(ifa.o_rsp_valid), 32'd0);
        chk("mid_busy_a", 32'(ifa.o_busy),      32'd0);
        tick();
        chk("mid_rspv_b", 32'(ifa.o_rsp_valid), 32'd0);
        chk("mid_busy_b", 32'(ifa.o_busy),      32'd0);
        ifa.i_req_valid = 4'b1111;
        #1;
        chk("mid_ptr0", 32'(ifa.o_req_ready), 32'h1);
        ifa.i_req_valid = 4'b0000;
        #1;

        // Latency sweep on the MUL_LAT=3 instance.
        ifb.i_req_valid = 4'b0001;
        #1;
        chk("lat_rdy0", 32'(ifb.o_req_ready), 32'h1);
        tick();
        ifb.i_req_valid = 4'b0010;
        #1;
        chk("lat_rdy1", 32'(ifb.o_req_ready), 32'h2);
        tick();
        ifb.i_req_valid = 4'b0000;
        for (int j = 2; j <= 7; j++) begin
            #1;
            if (j == 5) begin
                chk("lat_rspv5", 32'(ifb.o_rsp_valid), 32'h1);
                chk("lat_rspd5", 32'(ifb.o_rsp_data),  32'(prod_fn(opa[0], opb[0])));
            end else if (j == 6) begin
                chk("lat_rspv6", 32'(ifb.o_rsp_valid), 32'h2);
                chk("lat_rspd6", 32'(ifb.o_rsp_data),  32'(prod_fn(opa[1], opb[1])));
            end else begin
                chk($sformatf("lat_idle%0d", j), 32'(ifb.o_rsp_valid), 32'd0);
            end
            if (j == 7)
                chk("lat_busy7", 32'(ifb.o_busy), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
